// File: rtl/u32_to_fp_arbiter.sv
// rtl/u32_to_fp_arbiter.sv - round-robin arbiter sharing one pipelined U32-to-float converter
// Tags ride a shadow pipeline that advances in lockstep with the converter's clock enable.
module u32_to_fp_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_STAGES = 6,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*32-1:0]             req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [31:0]                       cvt_i,
  output logic                              cvt_ce,
  input  logic [33:0]                       cvt_o,
  output logic                              rsp_valid,
  output logic [ID_W-1:0]                   rsp_id,
  output logic [33:0]                       rsp_data,
  input  logic                              rsp_ready,
  output logic [$clog2(NUM_STAGES+2)-1:0]   inflight
);

  localparam int CNT_W = $clog2(NUM_STAGES+2);

  logic [31:0]     ops [NUM_REQ];
  logic            vld [1:NUM_STAGES];
  logic [ID_W-1:0] tag [1:NUM_STAGES];
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gidx;
  logic            found;
  logic            req_hs;
  logic            rsp_hs;
  logic [NUM_REQ-1:0] grant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
    assign ops[i] = req_data[32*i +: 32];
  end

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int              cand;
    logic [ID_W-1:0] idx;
    cand  = 0;
    idx   = '0;
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      idx = cand[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  assign cvt_ce    = !(vld[NUM_STAGES] && !rsp_ready);
  assign grant     = found ? (NUM_REQ'(1) << gidx) : '0;
  assign req_ready = grant & {NUM_REQ{cvt_ce}};
  assign req_hs    = found && cvt_ce;
  assign cvt_i     = found ? ops[gidx] : 32'h0;

  assign rsp_valid = vld[NUM_STAGES];
  assign rsp_id    = tag[NUM_STAGES];
  assign rsp_data  = cvt_o;
  assign rsp_hs    = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 1; s <= NUM_STAGES; s++) begin
        vld[s] <= 1'b0;
        tag[s] <= '0;
      end
      ptr      <= '0;
      inflight <= '0;
    end else begin
      if (cvt_ce) begin
        vld[1] <= req_hs;
        tag[1] <= gidx;
        for (int s = 2; s <= NUM_STAGES; s++) begin
          vld[s] <= vld[s-1];
          tag[s] <= tag[s-1];
        end
      end
      if (req_hs) begin
        ptr <= (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + ID_W'(1);
      end
      case ({req_hs, rsp_hs})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
